// File: rtl/cim_pkg.sv
// cim_pkg: shared state encoding and derived-width helpers for the CIM core
package cim_pkg;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  function automatic int cim_aw(input int rows);
    return $clog2(rows);
  endfunction
  function automatic int cim_psum_w(input int wbits, input int abits, input int rows);
    return wbits + abits + $clog2(rows);
  endfunction
  function automatic int cim_nstep(input int rows, input int rpc);
    return rows / rpc;
  endfunction
  function automatic int cim_chw(input int nch);
    return nch > 1 ? $clog2(nch) : 1;
  endfunction
endpackage

// File: rtl/cim_mac_slice.sv
// cim_mac_slice: one column's RPC-row multiply and adder tree (combinational); w/a in, sum out; CIM_SIGNED_W_EN makes weights signed
module cim_mac_slice
  import cim_pkg::*;
#(
  parameter int WBITS  = 4,
  parameter int ABITS  = 4,
  parameter int RPC    = 8,
  parameter int PSUM_W = 14
) (
  input  logic [RPC*WBITS-1:0] w,
  input  logic [RPC*ABITS-1:0] a,
  output logic [PSUM_W-1:0]    sum
);
  always_comb begin
    sum = '0;
    for (int k = 0; k < RPC; k++) begin
`ifdef CIM_SIGNED_W_EN
      sum = sum + PSUM_W'($signed(w[k*WBITS +: WBITS])) * PSUM_W'(a[k*ABITS +: ABITS]);
`else
      sum = sum + PSUM_W'(w[k*WBITS +: WBITS]) * PSUM_W'(a[k*ABITS +: ABITS]);
`endif
    end
  end
endmodule

// File: rtl/cim_core_mc.sv
// cim_core_mc: multi-channel CIM core; weight SRAM port (wr_en/rd_en/addr/wdata/rdata), activation burst in (act_*), per-channel psums out (psum_*), busy/acc_err status; CIM_SIGNED_W_EN selects signed weights
module cim_core_mc
  import cim_pkg::*;
#(
  parameter  int ROWS   = 64,
  parameter  int COLS   = 72,
  parameter  int WBITS  = 4,
  parameter  int ABITS  = 4,
  parameter  int NCH    = 3,
  parameter  int RPC    = 8,
  localparam int AW     = cim_aw(ROWS),
  localparam int PSUM_W = cim_psum_w(WBITS, ABITS, ROWS),
  localparam int NSTEP  = cim_nstep(ROWS, RPC),
  localparam int CW     = cim_chw(NCH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [AW-1:0]               addr,
  input  logic [COLS*WBITS-1:0]       wdata,
  output logic [COLS*WBITS-1:0]       rdata,
  output logic                        rdata_valid,
  input  logic                        act_valid,
  output logic                        act_ready,
  input  logic [NCH*ROWS*ABITS-1:0]   act_data,
  output logic                        psum_valid,
  input  logic                        psum_ready,
  output logic [CW-1:0]               psum_ch,
  output logic [COLS*PSUM_W-1:0]      psum_data,
  output logic                        busy,
  output logic                        acc_err
);
  state_t                      state;
  logic [COLS*WBITS-1:0]       mem [ROWS];
  logic [NCH*ROWS*ABITS-1:0]   act_q;
  logic [AW-1:0]               row;
  logic [CW-1:0]               ch;
  logic [PSUM_W-1:0]           acc [COLS];
  logic [PSUM_W-1:0]           sum [COLS];
  logic                        idle;
  assign idle      = state == IDLE;
  assign busy      = !idle;
  assign act_ready = idle && !rst;
  always_ff @(posedge clk)
    if (!rst && idle && wr_en) mem[addr] <= wdata;
  // Channels sit back to back in act_q, so shifting out RPC rows per ACC
  // cycle walks row-by-row through channel 0, then 1, and so on.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [RPC*WBITS-1:0] w;
    for (genvar k = 0; k < RPC; k++) begin : g_row
      assign w[k*WBITS +: WBITS] = mem[row + AW'(k)][j*WBITS +: WBITS];
    end
    cim_mac_slice #(.WBITS(WBITS), .ABITS(ABITS), .RPC(RPC), .PSUM_W(PSUM_W)) u_mac (
      .w  (w),
      .a  (act_q[RPC*ABITS-1:0]),
      .sum(sum[j])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      ch          <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      psum_valid  <= 1'b0;
      psum_ch     <= '0;
      psum_data   <= '0;
      acc_err     <= 1'b0;
      for (int j = 0; j < COLS; j++) acc[j] <= '0;
    end else begin
      rdata_valid <= idle && rd_en && !wr_en;
      if (idle && rd_en && !wr_en) rdata <= mem[addr];
      if (!idle && (wr_en || rd_en)) acc_err <= 1'b1;
      case (state)
        IDLE: if (act_valid) begin
          act_q <= act_data;
          row   <= '0;
          ch    <= '0;
          state <= ACC;
          for (int j = 0; j < COLS; j++) acc[j] <= '0;
        end
        ACC: begin
          row   <= row + AW'(RPC);
          act_q <= act_q >> (RPC*ABITS);
          for (int j = 0; j < COLS; j++) begin
            acc[j] <= acc[j] + sum[j];
            if (row == AW'((NSTEP-1)*RPC)) psum_data[j*PSUM_W +: PSUM_W] <= acc[j] + sum[j];
          end
          if (row == AW'((NSTEP-1)*RPC)) begin
            state      <= OUT;
            psum_valid <= 1'b1;
            psum_ch    <= ch;
          end
        end
        OUT: if (psum_ready) begin
          psum_valid <= 1'b0;
          if (ch != CW'(NCH-1)) begin
            ch    <= ch + CW'(1);
            row   <= '0;
            state <= ACC;
            for (int j = 0; j < COLS; j++) acc[j] <= '0;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cim_core_mc.sv
// tb_cim_core_mc: directed self-checking bench for cim_core_mc at default size plus a small sweep instance
module tb_cim_core_mc;
  localparam int ROWS = 64, COLS = 72, WBITS = 4, ABITS = 4, NCH = 3, PSUM_W = 14, AW = 6;
  logic clk = 1'b0;
  logic rst;
  logic wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [COLS*WBITS-1:0] wdata, rdata;
  logic rdata_valid, act_valid, act_ready;
  logic [NCH*ROWS*ABITS-1:0] act_data;
  logic psum_valid, psum_ready;
  logic [1:0] psum_ch;
  logic [COLS*PSUM_W-1:0] psum_data;
  logic busy, acc_err;
  logic s_wr_en, s_rd_en;
  logic [3:0] s_addr;
  logic [15:0] s_wdata, s_rdata;
  logic s_rdata_valid, s_act_valid, s_act_ready;
  logic [63:0] s_act_data;
  logic s_psum_valid, s_psum_ready;
  logic [0:0] s_psum_ch;
  logic [47:0] s_psum_data;
  logic s_busy, s_acc_err;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  cim_core_mc dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .act_valid(act_valid), .act_ready(act_ready),
    .act_data(act_data), .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_ch(psum_ch),
    .psum_data(psum_data), .busy(busy), .acc_err(acc_err)
  );
  cim_core_mc #(.ROWS(16), .COLS(4), .WBITS(4), .ABITS(4), .NCH(1), .RPC(16)) dut_s (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .rd_en(s_rd_en), .addr(s_addr), .wdata(s_wdata),
    .rdata(s_rdata), .rdata_valid(s_rdata_valid), .act_valid(s_act_valid), .act_ready(s_act_ready),
    .act_data(s_act_data), .psum_valid(s_psum_valid), .psum_ready(s_psum_ready), .psum_ch(s_psum_ch),
    .psum_data(s_psum_data), .busy(s_busy), .acc_err(s_acc_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [WBITS-1:0] w);
    for (int r = 0; r < ROWS; r++) begin
      wr_en = 1'b1;
      addr  = AW'(r);
      wdata = {COLS{w}};
      tick();
    end
    wr_en = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!psum_valid && n < 50) begin
      tick();
      n++;
    end
  endtask
  task automatic burst_start(input logic [ABITS-1:0] a);
    act_data  = {NCH*ROWS{a}};
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    {wr_en, rd_en, act_valid, psum_ready} = '0;
    {s_wr_en, s_rd_en, s_act_valid, s_psum_ready} = '0;
    addr = '0; wdata = '0; act_data = '0;
    s_addr = '0; s_wdata = '0; s_act_data = '0;
    tick();
    tick();
    checks++;
    if ({rdata_valid, act_ready, psum_valid, busy, acc_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {rdata_valid, act_ready, psum_valid, busy, acc_err});
    end
    checks++;
    if (psum_data !== '0 || rdata !== '0 || psum_ch !== 2'd0) begin
      failures++;
      $display("FAIL reset_data psum_ch=%0d rdata_nz=%b psum_nz=%b want zeros", psum_ch, |rdata, |psum_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (act_ready !== 1'b1 || s_act_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release act_ready=%b s_act_ready=%b want 1", act_ready, s_act_ready);
    end
  endtask
  task automatic test_rw();
    logic [COLS*WBITS-1:0] pat;
    for (int j = 0; j < COLS; j++) pat[j*WBITS +: WBITS] = WBITS'(j % 16);
    wr_en = 1'b1; addr = 6'd35; wdata = pat;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== pat) begin
      failures++;
      $display("FAIL read_row35 valid=%b got=%h want=%h", rdata_valid, rdata, pat);
    end
    tick();
    checks++;
    if (rdata_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_pulse valid=%b want 0", rdata_valid);
    end
    wr_en = 1'b1; rd_en = 1'b1; wdata = ~pat;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (rdata_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_collision valid=%b want 0", rdata_valid);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rdata !== ~pat) begin
      failures++;
      $display("FAIL write_wins got=%h want=%h", rdata, ~pat);
    end
  endtask
  task automatic test_burst_ones();
    int n;
    fill(4'd1);
    psum_ready = 1'b1;
    burst_start(4'd1);
    for (int c = 0; c < NCH; c++) begin
      wait_valid(n);
      checks++;
      if (n !== 8) begin
        failures++;
        $display("FAIL ones_latency ch=%0d got=%0d want=8 cycles after ACC start", c, n);
      end
      checks++;
      if (psum_ch !== 2'(c) || psum_data !== {COLS{14'd64}}) begin
        failures++;
        $display("FAIL ones_result ch got=%0d want=%0d col0 got=%0d want=64", psum_ch, c, psum_data[PSUM_W-1:0]);
      end
      tick();
    end
    checks++;
    if (act_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ones_idle act_ready=%b busy=%b want 1/0", act_ready, busy);
    end
  endtask
  task automatic test_stall();
    int n;
    psum_ready = 1'b0;
    burst_start(4'd1);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      act_valid = (i == 3);
      act_data  = {NCH*ROWS{4'd15}};
      wr_en     = (i == 6);
      addr      = 6'd0;
      wdata     = '0;
      checks++;
      if (psum_valid !== 1'b1 || psum_ch !== 2'd0 || psum_data !== {COLS{14'd64}}) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b ch=%0d col0=%0d want 1/0/64", i, psum_valid, psum_ch, psum_data[PSUM_W-1:0]);
      end
      tick();
    end
    act_valid = 1'b0; wr_en = 1'b0;
    checks++;
    if (acc_err !== 1'b1) begin
      failures++;
      $display("FAIL stall_acc_err got=%b want 1", acc_err);
    end
    psum_ready = 1'b1;
    for (int c = 1; c < NCH; c++) begin
      tick();
      wait_valid(n);
      checks++;
      if (psum_ch !== 2'(c) || psum_data !== {COLS{14'd64}}) begin
        failures++;
        $display("FAIL stall_next ch got=%0d want=%0d col0 got=%0d want 64", psum_ch, c, psum_data[PSUM_W-1:0]);
      end
    end
    tick();
    rd_en = 1'b1; addr = 6'd0;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rdata !== {COLS{4'd1}}) begin
      failures++;
      $display("FAIL stall_row_kept got=%h want all 1", rdata);
    end
  endtask
  task automatic test_max();
    int n;
    logic [PSUM_W-1:0] e;
`ifdef CIM_SIGNED_W_EN
    fill(4'b1000);
    e = 14'd8704;
`else
    fill(4'd15);
    e = 14'd14400;
`endif
    psum_ready = 1'b1;
    burst_start(4'd15);
    for (int c = 0; c < NCH; c++) begin
      wait_valid(n);
      checks++;
      if (psum_ch !== 2'(c) || psum_data !== {COLS{e}}) begin
        failures++;
        $display("FAIL max_result ch got=%0d want=%0d col0 got=%0d want=%0d", psum_ch, c, psum_data[PSUM_W-1:0], e);
      end
      tick();
    end
  endtask
  task automatic test_rst_mid();
    int n;
    logic [PSUM_W-1:0] e;
`ifdef CIM_SIGNED_W_EN
    e = 14'd8704;
`else
    e = 14'd14400;
`endif
    psum_ready = 1'b1;
    wr_en = 1'b1; addr = 6'd3;
    tick();
    wr_en = 1'b0;
    burst_start(4'd15);
    wait_valid(n);
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || psum_valid !== 1'b0 || acc_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid busy=%b psum_valid=%b acc_err=%b want 0/0/0", busy, psum_valid, acc_err);
    end
    rst = 1'b0;
    repeat (12) begin
      tick();
      checks++;
      if (psum_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_stray psum_valid=%b want 0", psum_valid);
      end
    end
    burst_start(4'd15);
    for (int c = 0; c < NCH; c++) begin
      wait_valid(n);
      checks++;
      if (psum_ch !== 2'(c) || psum_data !== {COLS{e}}) begin
        failures++;
        $display("FAIL rst_retained ch got=%0d want=%0d col0 got=%0d want=%0d", psum_ch, c, psum_data[PSUM_W-1:0], e);
      end
      tick();
    end
  endtask
  task automatic test_sweep();
    int n;
    for (int r = 0; r < 16; r++) begin
      s_wr_en = 1'b1; s_addr = 4'(r); s_wdata = {4'd4, 4'd3, 4'd2, 4'd1};
      tick();
    end
    s_wr_en = 1'b0;
    s_psum_ready = 1'b1;
    s_act_data = {16{4'd2}};
    s_act_valid = 1'b1;
    tick();
    s_act_valid = 1'b0;
    n = 0;
    while (!s_psum_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL sweep_latency got=%0d want=1", n);
    end
    checks++;
    if (s_psum_ch !== 1'b0 || s_psum_data !== {12'd128, 12'd96, 12'd64, 12'd32}) begin
      failures++;
      $display("FAIL sweep_result ch=%0d got=%h want=%h", s_psum_ch, s_psum_data, {12'd128, 12'd96, 12'd64, 12'd32});
    end
    tick();
    checks++;
    if (s_act_ready !== 1'b1 || s_psum_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_idle act_ready=%b psum_valid=%b want 1/0", s_act_ready, s_psum_valid);
    end
  endtask
  initial begin
    test_reset();
    test_rw();
    test_burst_ones();
    test_stall();
    test_max();
    test_rst_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
